// File: rtl/life_vga_pkg.sv
// rtl/life_vga_pkg.sv - shared widths, colours and cell addressing for the life grid renderer
// Purpose: coordinate/colour widths, default colour constants and the
//          row-major cell address helper used by life_grid_renderer.
package life_vga_pkg;

  localparam int COORD_W = 11;
  localparam int RGB_W   = 12;

  localparam logic [RGB_W-1:0] C_ALIVE_RGB    = 12'hFFF;
  localparam logic [RGB_W-1:0] C_DEAD_RGB     = 12'h000;
  localparam logic [RGB_W-1:0] C_CURSOR_RGB   = 12'hF00;
  localparam logic [RGB_W-1:0] C_GRIDLINE_RGB = 12'h444;

  // Row-major cell index: row*grid_w + col.
  function automatic int unsigned cell_addr(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned grid_w);
    return row * grid_w + col;
  endfunction

endpackage

// File: rtl/life_sync_delay.sv
// rtl/life_sync_delay.sv - strobe-enabled shift register for sync/blank alignment
// Purpose: delays a W-bit control bundle by DEPTH enabled cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : shift enable (pixel strobe)
//   d          : bundle in
//   q          : bundle delayed by DEPTH strobes (RST_VAL while in reset)
module life_sync_delay #(
  parameter int           DEPTH   = 2,
  parameter int           W       = 3,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
    end else if (en) begin
      r_sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign q = r_sr[DEPTH-1];

endmodule

// File: rtl/life_grid_renderer.sv
// rtl/life_grid_renderer.sv - pipelined Conway grid renderer with blinking cursor
// Purpose: maps VGA pixel coordinates onto a GRID_W x GRID_H cell array held
//          in an external synchronous 1-bit RAM and emits RGB plus sync/blank
//          delayed by two pixel strobes. Optional grid lines: LIFE_GRID_LINES_EN.
// Ports:
//   clk, rst_n              : pixel-domain clock, asynchronous active-low reset
//   pix_en                  : pixel strobe, pipeline advances only when high
//   x, y                    : current pixel column/row
//   hsync_in/vsync_in       : timing generator syncs (vsync active low)
//   blank_in                : high outside visible area
//   cursor_x, cursor_y      : cursor cell, latched on each vsync falling edge
//   rd_en, rd_addr, rd_data : cell RAM read port (data valid the clk after rd_en)
//   rgb                     : pixel colour
//   hsync_out/vsync_out/blank_out : inputs delayed by 2 strobes
module life_grid_renderer
  import life_vga_pkg::*;
#(
  parameter int               GRID_W     = 64,
  parameter int               GRID_H     = 48,
  parameter int               CELL_LOG2  = 3,
  parameter int               X_OFF      = 64,
  parameter int               Y_OFF      = 48,
  parameter logic [RGB_W-1:0] ALIVE_RGB  = C_ALIVE_RGB,
  parameter logic [RGB_W-1:0] DEAD_RGB   = C_DEAD_RGB,
  parameter logic [RGB_W-1:0] CURSOR_RGB = C_CURSOR_RGB,
  parameter int               BLINK_LOG2 = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              pix_en,
  input  logic [COORD_W-1:0]                x,
  input  logic [COORD_W-1:0]                y,
  input  logic                              hsync_in,
  input  logic                              vsync_in,
  input  logic                              blank_in,
  input  logic [$clog2(GRID_W)-1:0]         cursor_x,
  input  logic [$clog2(GRID_H)-1:0]         cursor_y,
  output logic                              rd_en,
  output logic [$clog2(GRID_W*GRID_H)-1:0]  rd_addr,
  input  logic                              rd_data,
  output logic [RGB_W-1:0]                  rgb,
  output logic                              hsync_out,
  output logic                              vsync_out,
  output logic                              blank_out
);

  localparam int CX_W = $clog2(GRID_W);
  localparam int CY_W = $clog2(GRID_H);
  localparam int A_W  = $clog2(GRID_W * GRID_H);
  localparam int FC_W = BLINK_LOG2 + 1;

  localparam logic [COORD_W-1:0] X_LO = COORD_W'(X_OFF);
  localparam logic [COORD_W-1:0] X_HI = COORD_W'(X_OFF + (GRID_W << CELL_LOG2));
  localparam logic [COORD_W-1:0] Y_LO = COORD_W'(Y_OFF);
  localparam logic [COORD_W-1:0] Y_HI = COORD_W'(Y_OFF + (GRID_H << CELL_LOG2));

  logic [COORD_W-1:0] w_dx, w_dy, w_col, w_row;
  logic               w_in_grid, w_hit, w_frame, w_blink_on;
  logic [A_W-1:0]     w_addr;
  logic [RGB_W-1:0]   w_rgb;
  logic [2:0]         w_sync_q;

  logic [CX_W-1:0]    r_cur_x;
  logic [CY_W-1:0]    r_cur_y;
  logic [FC_W-1:0]    r_frame_cnt;
  logic               r_vs_prev;
  logic               r_s1_in_grid, r_s1_hit, r_s1_blank;

  // Offsets wrap when the pixel is left of / above the grid, but only feed
  // rd_addr and cursor_hit through in_grid, so the wrap is never visible.
  assign w_dx  = x - X_LO;
  assign w_dy  = y - Y_LO;
  assign w_col = w_dx >> CELL_LOG2;
  assign w_row = w_dy >> CELL_LOG2;

  assign w_in_grid = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI) && !blank_in;
  assign w_addr    = A_W'(cell_addr(32'(w_row), 32'(w_col), 32'(GRID_W)));

  // An out-of-range latched cursor never matches.
  assign w_hit = (w_col == COORD_W'(r_cur_x)) && (w_row == COORD_W'(r_cur_y)) &&
                 (32'(r_cur_x) < 32'(GRID_W)) && (32'(r_cur_y) < 32'(GRID_H));

  assign w_frame    = pix_en && r_vs_prev && !vsync_in;
  assign w_blink_on = r_frame_cnt[FC_W-1];

`ifdef LIFE_GRID_LINES_EN
  logic w_line, r_s1_line;
  assign w_line = (w_dx[CELL_LOG2-1:0] == '0) || (w_dy[CELL_LOG2-1:0] == '0);
`endif

  // S0 issues the RAM read; S1 captures per-pixel attributes; frame logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      r_s1_in_grid <= 1'b0;
      r_s1_hit     <= 1'b0;
      r_s1_blank   <= 1'b1;
      r_vs_prev    <= 1'b1;
      r_cur_x      <= '0;
      r_cur_y      <= '0;
      r_frame_cnt  <= '0;
`ifdef LIFE_GRID_LINES_EN
      r_s1_line    <= 1'b0;
`endif
    end else begin
      // rd_en is a single-clk pulse even when strobes are sparse.
      rd_en <= pix_en && w_in_grid;
      if (pix_en) begin
        if (w_in_grid) rd_addr <= w_addr;
        r_s1_in_grid <= w_in_grid;
        r_s1_hit     <= w_hit;
        r_s1_blank   <= blank_in;
        r_vs_prev    <= vsync_in;
`ifdef LIFE_GRID_LINES_EN
        r_s1_line    <= w_line;
`endif
        if (w_frame) begin
          r_cur_x     <= cursor_x;
          r_cur_y     <= cursor_y;
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  // rd_data has settled one clk after the S0 strobe, ahead of the next strobe.
  always_comb begin
    w_rgb = DEAD_RGB;
    if (r_s1_blank)                   w_rgb = '0;
    else if (!r_s1_in_grid)           w_rgb = DEAD_RGB;
    else if (r_s1_hit && w_blink_on)  w_rgb = CURSOR_RGB;
`ifdef LIFE_GRID_LINES_EN
    else if (r_s1_line)               w_rgb = C_GRIDLINE_RGB;
`endif
    else if (rd_data)                 w_rgb = ALIVE_RGB;
    else                              w_rgb = DEAD_RGB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rgb <= '0;
    else if (pix_en) rgb <= w_rgb;
  end

  life_sync_delay #(.DEPTH(2), .W(3), .RST_VAL(3'b111)) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .d     ({hsync_in, vsync_in, blank_in}),
    .q     (w_sync_q)
  );

  assign hsync_out = w_sync_q[2];
  assign vsync_out = w_sync_q[1];
  assign blank_out = w_sync_q[0];

endmodule

// File: tb/tb_life_grid_renderer.sv
// tb/tb_life_grid_renderer.sv - directed self-checking bench for life_grid_renderer
module tb_life_grid_renderer;

  logic        clk = 1'b0;
  logic        rst_n, pix_en;
  logic [10:0] x, y;
  logic        hsync_in, vsync_in, blank_in;
  logic [5:0]  cursor_x, cursor_y;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic        rd_data = 1'b0;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, blank_out;

  int n_checks = 0;
  int n_errors = 0;

  logic ram [3072];

  // Bench-side cursor/frame model.
  int       cur_lx = 0;
  int       cur_ly = 0;
  logic [5:0] fc = '0;

  life_grid_renderer dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x), .y(y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         px;
    int         py;
    logic       blank;
    logic       hs;
    logic       exp_rd_en;
    int         exp_addr;
    logic [11:0] exp_rgb;
    logic [11:0] exp_rgb_gl;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One strobe with an idle clk after it; returns at the mid-idle sample point.
  task automatic strobe(input int px, input int py, input logic b, input logic hs, input logic vs);
    @(negedge clk);
    x = 11'(px); y = 11'(py); blank_in = b; hsync_in = hs; vsync_in = vs;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  function automatic logic [11:0] sel_rgb(input logic [11:0] plain, input logic [11:0] gl);
`ifdef LIFE_GRID_LINES_EN
    return gl;
`else
    return plain;
`endif
  endfunction

  function automatic logic [11:0] model_rgb(input int px, input int py);
    int col, row;
    col = (px - 64) >> 3;
    row = (py - 48) >> 3;
    if (col == cur_lx && row == cur_ly && cur_lx < 64 && cur_ly < 48 && fc[5]) return 12'hF00;
`ifdef LIFE_GRID_LINES_EN
    if (((px - 64) % 8 == 0) || ((py - 48) % 8 == 0)) return 12'h444;
`endif
    return ram[row*64 + col] ? 12'hFFF : 12'h000;
  endfunction

  task automatic check_px(input int px, input int py, input string name);
    strobe(px, py, 1'b0, 1'b1, 1'b1);
    strobe(0, 0, 1'b1, 1'b1, 1'b1);
    chk(name, 32'(rgb), 32'(model_rgb(px, py)));
  endtask

  task automatic frame_event();
    strobe(0, 0, 1'b1, 1'b1, 1'b0);
    cur_lx = int'(cursor_x);
    cur_ly = int'(cursor_y);
    fc     = fc + 6'd1;
    strobe(0, 0, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    vecs[0]  = '{64,  48,  1'b0, 1'b1, 1'b1, 0,    12'hFFF, 12'h444};
    vecs[1]  = '{575, 431, 1'b0, 1'b0, 1'b1, 3071, 12'hFFF, 12'hFFF};
    vecs[2]  = '{576, 48,  1'b0, 1'b1, 1'b0, 3071, 12'h000, 12'h000};
    vecs[3]  = '{63,  100, 1'b0, 1'b0, 1'b0, 3071, 12'h000, 12'h000};
    vecs[4]  = '{72,  48,  1'b0, 1'b1, 1'b1, 1,    12'h000, 12'h444};
    vecs[5]  = '{100, 60,  1'b1, 1'b1, 1'b0, 1,    12'h000, 12'h000};
    vecs[6]  = '{81,  57,  1'b0, 1'b0, 1'b1, 66,   12'hFFF, 12'hFFF};
    vecs[7]  = '{80,  56,  1'b0, 1'b1, 1'b1, 66,   12'hFFF, 12'h444};
    vecs[8]  = '{80,  50,  1'b0, 1'b0, 1'b1, 2,    12'h000, 12'h444};
    vecs[9]  = '{81,  50,  1'b0, 1'b1, 1'b1, 2,    12'h000, 12'h000};
    vecs[10] = '{639, 479, 1'b0, 1'b0, 1'b0, 2,    12'h000, 12'h000};
    vecs[11] = '{0,   0,   1'b1, 1'b1, 1'b0, 2,    12'h000, 12'h000};

    for (int i = 0; i < 3072; i++) ram[i] = 1'b0;
    ram[0] = 1'b1; ram[3071] = 1'b1; ram[66] = 1'b1; ram[68] = 1'b1;

    rst_n = 1'b0; pix_en = 1'b0; x = '0; y = '0;
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
    cursor_x = '0; cursor_y = '0;

    repeat (3) @(negedge clk);
    chk("reset_rgb",   32'(rgb),       32'h0);
    chk("reset_rd_en", 32'(rd_en),     32'h0);
    chk("reset_hs",    32'(hsync_out), 32'h1);
    chk("reset_blank", 32'(blank_out), 32'h1);
    rst_n = 1'b1;

    // Table: rd port checked on the strobe itself, colour/syncs one strobe later.
    for (int i = 0; i < 12; i++) begin
      strobe(vecs[i].px, vecs[i].py, vecs[i].blank, vecs[i].hs, 1'b1);
      chk($sformatf("v%0d_rd_en", i),   32'(rd_en),   32'(vecs[i].exp_rd_en));
      chk($sformatf("v%0d_rd_addr", i), 32'(rd_addr), 32'(vecs[i].exp_addr));
      if (i == 0) begin
        chk("v0_rgb_not_yet", 32'(rgb), 32'h0);
      end else begin
        chk($sformatf("v%0d_rgb", i-1),   32'(rgb),       32'(sel_rgb(vecs[i-1].exp_rgb, vecs[i-1].exp_rgb_gl)));
        chk($sformatf("v%0d_hs", i-1),    32'(hsync_out), 32'(vecs[i-1].hs));
        chk($sformatf("v%0d_blank", i-1), 32'(blank_out), 32'(vecs[i-1].blank));
        chk($sformatf("v%0d_vs", i-1),    32'(vsync_out), 32'h1);
      end
    end

    // Stalls: long pix_en gaps must not disturb outputs or the held rd_data.
    strobe(575, 431, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("stall0_rgb",   32'(rgb),   32'h000);
    chk("stall0_rd_en", 32'(rd_en), 32'h0);
    strobe(72, 48, 1'b0, 1'b1, 1'b1);
    chk("resume0_rgb", 32'(rgb),       32'hFFF);
    chk("resume0_hs",  32'(hsync_out), 32'h0);
    repeat (5) @(negedge clk);
    chk("stall1_rgb", 32'(rgb),       32'hFFF);
    chk("stall1_hs",  32'(hsync_out), 32'h0);
    strobe(64, 48, 1'b0, 1'b0, 1'b1);
    chk("resume1_rgb",     32'(rgb),       32'(sel_rgb(12'h000, 12'h444)));
    chk("resume1_hs",      32'(hsync_out), 32'h1);
    chk("resume1_rd_addr", 32'(rd_addr),   32'h0);

    // Asynchronous reset mid-line, between clock edges.
    strobe(81, 57, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_rgb", 32'(rgb),       32'(sel_rgb(12'hFFF, 12'h444)));
    chk("pre_rst_hs",  32'(hsync_out), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rgb",     32'(rgb),       32'h0);
    chk("midrst_hs",      32'(hsync_out), 32'h1);
    chk("midrst_vs",      32'(vsync_out), 32'h1);
    chk("midrst_blank",   32'(blank_out), 32'h1);
    chk("midrst_rd_en",   32'(rd_en),     32'h0);
    chk("midrst_rd_addr", 32'(rd_addr),   32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    strobe(64, 48, 1'b0, 1'b1, 1'b1);
    chk("post_rst_first_rgb",   32'(rgb),       32'h0);
    chk("post_rst_first_blank", 32'(blank_out), 32'h1);
    strobe(0, 0, 1'b1, 1'b1, 1'b1);
    chk("post_rst_second_rgb",   32'(rgb),       32'(sel_rgb(12'hFFF, 12'h444)));
    chk("post_rst_second_blank", 32'(blank_out), 32'h0);

    // Cursor: set mid-frame, latched on vsync fall, blinking on counter MSB.
    cursor_x = 6'd1; cursor_y = 6'd0;
    check_px(72, 48, "cursor_pre_frame");
    for (int f = 1; f <= 70; f++) begin
      frame_event();
      check_px(72, 48, $sformatf("frame%0d_c1", f));
      check_px(80, 48, $sformatf("frame%0d_c2", f));
      if (f == 40) begin
        cursor_x = 6'd2;
        check_px(72, 48, "frame40_midchange_c1");
        check_px(80, 48, "frame40_midchange_c2");
      end
      if (f == 50) cursor_y = 6'd50;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
